sobel_edge_stream: RTL and testbench
====================================

// Module: sobel_edge_stream
// PURPOSE
//  Downstream consumer of the RGB-to-grayscale stage. Takes its gray pixel stream (one 8-bit pixel per
//  valid cycle, raster order) and buffers two image lines. It forms a 3x3 window and emits the Sobel
//  edge magnitude |Gx|+|Gy|, saturated or thresholded to 8 bits, toward the Avalon output side.
//  Output image covers interior pixels only: (IMG_H-2) x (IMG_W-2), raster order.
// PARAMETERS
//  IMG_W      640  pixels per line (>=3)
//  IMG_H      480  lines per frame (>=3)
//  THRESHOLD  0    0: output=min(mag,255); else output = (mag>=THRESHOLD) ? 8'd255 : 8'd0
// PORTS
//  clk_i         in   1   single clock, all logic on rising edge
//  rst_i         in   1   synchronous, active-high reset
//  start_i       in   1   1-cycle pulse: begin new frame (clears counters/pipeline valids)
//  GrayValid_i   in   1   GrayColor_i holds a pixel this cycle (from gray stage valid_o)
//  GrayColor_i   in   8   gray pixel, unsigned
//  busy_o        out  1   high from frame start until last input pixel accepted
//  EdgeValid_o   out  1   EdgePixel_o valid this cycle (1-cycle strobe per output pixel)
//  EdgePixel_o   out  8   edge magnitude, unsigned
//  done_o        out  1   1-cycle pulse coincident with the last EdgeValid_o of the frame
// BEHAVIOUR
//  - Reset: FSM=IDLE, col/row=0, window regs=0, pipeline valids=0; busy_o=0, EdgeValid_o=0,
//    EdgePixel_o=0, done_o=0. Line-buffer RAM contents need no reset.
//  - FSM IDLE -> RUN on start_i. RUN -> IDLE in the cycle after the pixel at (row IMG_H-1, col IMG_W-1)
//    is accepted. busy_o = (state==RUN). GrayValid_i in IDLE is ignored (no counter/buffer change).
//  - start_i in RUN restarts: col/row=0, stage valids cleared, in-flight outputs dropped, no done_o.
//    Stale line-buffer data is harmless: outputs are gated by row>=2.
//  - Accept = RUN & GrayValid_i. On accept: col++ (wrap at IMG_W-1 -> 0, row++). Both line buffers shift
//    one entry. The 3x3 window shifts left one column, with new column {lb2_out, lb1_out, pixel} (top..bottom).
//  - Gaps in GrayValid_i stall everything; no pixel lost/duplicated; output timing moves with input.
//  - Output for accepted pixel (r,c) is produced iff r>=2 && c>=2; its window is centred at (r-1,c-1).
//  - Window p[y][x], y=0 top, x=0 left. Gx=(p02+2p12+p22)-(p00+2p10+p20);
//    Gy=(p20+2p21+p22)-(p00+2p01+p02). Both are 11-bit signed (+-1020), so no overflow;
//    mag=|Gx|+|Gy| is 11-bit unsigned (<=2040).
//  - Latency: pixel accepted in cycle t -> window regs updated at end of t. Gradient/magnitude register
//    loads at end of t+1. EdgeValid_o/EdgePixel_o are visible in cycle t+1's next edge, i.e. asserted
//    during cycle t+2. The stage-1 -> stage-2 step is unconditional (not stalled), so EdgeValid_o is
//    exactly one cycle wide.
//  - EdgePixel_o holds its last value when EdgeValid_o=0.
//  - done_o asserted with EdgeValid_o for input pixel (IMG_H-1, IMG_W-1).
//  - A new start_i may arrive while the final 2 outputs drain. The drain completes; done_o still fires.
//  - rst_i mid-frame: immediate return to reset state, pending outputs discarded.
// STRUCTURE
//  - Shared package (gray_pipe_pkg): PIX_W=8, GRAD_W=11, MAG_W=11, FSM state encoding
//    (IDLE=1'b0, RUN=1'b1), clog2 helper for counters.
//  - Sub-module gray_line_buffer #(DEPTH=IMG_W, W=8). Circular RAM plus pointer. On en: outputs the
//    entry written DEPTH accepts ago and writes din. Two instances are chained: lb1 din=pixel,
//    lb2 din=lb1_out.
//  - Top: FSM + col/row counters, 3x3 window regs, gradient/abs/sum, saturation/threshold, output regs.
// TESTING (IMG_W=8, IMG_H=4 unless stated)
//  1 Flat image, all 100, continuous valid -> 12 EdgeValid_o strobes, all EdgePixel_o=0,
//    done_o on 12th, busy_o falls after 32nd accept.
//  2 Vertical step: cols 0-3=0, cols 4-7=255 -> per output row: 0,0,255,255,0,0 (sat. 1020->255).
//  3 THRESHOLD=200, image value=(col==4)?60:0 -> windows touching col4: Gx=+-240 -> outputs
//    0,0,255,0,255,0 per row; with THRESHOLD=300 all 0.
//  4 Test 2 with GrayValid_i toggled 1-0-1 and random 0-3 cycle gaps -> identical output sequence;
//    each EdgeValid_o exactly 2 cycles after its driving accept.
//  5 start_i at pixel 20 of frame, then full flat-50 frame -> no done_o for aborted frame, exactly
//    12 zero outputs then done_o; rst_i at pixel 20 -> all outputs 0 next cycle, IDLE.
//  6 Pixels during IDLE (before start_i) -> no output, counters unchanged; min-size IMG_W=3,IMG_H=3
//    -> exactly 1 output + done_o.

Source files
------------

// File: rtl/sobel_edge_stream_pkg.sv
// Shared definitions for the Sobel edge stage: pixel/gradient widths,
// FSM state encoding and a counter-width helper.
package sobel_edge_stream_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sobel_edge_stream_if.sv
// Stream bundle between the gray pixel source and the Sobel edge stage.
// master = pixel source / output sink, slave = the edge stage itself.
interface sobel_edge_stream_if;
    import sobel_edge_stream_pkg::*;

    logic             start;
    logic             gray_valid;
    logic [PIX_W-1:0] gray_color;
    logic             busy;
    logic             edge_valid;
    logic [PIX_W-1:0] edge_pixel;
    logic             done;

    modport master (
        output start, gray_valid, gray_color,
        input  busy, edge_valid, edge_pixel, done
    );

    modport slave (
        input  start, gray_valid, gray_color,
        output busy, edge_valid, edge_pixel, done
    );

endinterface

// File: rtl/sobel_edge_stream_line_buffer.sv
// One-line delay for the gray stream: a circular RAM plus write pointer.
// The read is combinational, so on an enabled cycle dout shows the entry
// written DEPTH enables ago while din overwrites it at the clock edge.
module gray_line_buffer
    import sobel_edge_stream_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    localparam int PTR_W = cnt_width(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign dout = mem[ptr];

    // Advance the circular pointer once per accepted pixel.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst_i) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Store the incoming pixel over the one just read out.
    always_ff @(posedge clk_i) begin
        // NOTE: RAM is deliberately not reset; stale lines are masked by the row gate downstream.
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// Sobel edge magnitude over a raster gray stream. Two chained line buffers
// feed a 3x3 window; |Gx|+|Gy| is saturated (THRESHOLD=0) or thresholded to
// 8 bits. Only interior pixels are emitted, two cycles after the accept.
module sobel_edge_stream
    import sobel_edge_stream_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int THRESHOLD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sobel_edge_stream_if.slave   stream
);
    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic             accept;
    logic             restart;
    logic             last_pix;

    logic [PIX_W-1:0] lb1_out;
    logic [PIX_W-1:0] lb2_out;
    logic [PIX_W-1:0] win [3][3];

    logic             s1_valid;
    logic             s1_last;

    logic signed [GRAD_W-1:0] gx;
    logic signed [GRAD_W-1:0] gy;
    logic [MAG_W-1:0]         abs_gx;
    logic [MAG_W-1:0]         abs_gy;
    logic [MAG_W-1:0]         mag;
    logic [PIX_W-1:0]         shaped;

    logic             edge_valid;
    logic [PIX_W-1:0] edge_pixel;
    logic             done;

    // A start seen while running wins over any pixel offered in the same cycle.
    assign restart  = stream.start && (state == RUN);
    assign accept   = (state == RUN) && stream.gray_valid && !stream.start;
    assign last_pix = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));

    gray_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (accept),
        .din   (stream.gray_color),
        .dout  (lb1_out)
    );

    gray_line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (accept),
        .din   (lb1_out),
        .dout  (lb2_out)
    );

    // Frame FSM with raster column/row counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stream.start) begin
                        state <= RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (stream.start) begin
                        col <= '0;
                        row <= '0;
                    end else if (accept) begin
                        if (last_pix) begin
                            state <= IDLE;
                            col   <= '0;
                            row   <= '0;
                        end else if (col == COL_W'(IMG_W - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift the 3x3 window left; new right column is {lb2, lb1, pixel}.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int y = 0; y < 3; y++) begin
                for (int x = 0; x < 3; x++) begin
                    win[y][x] <= '0;
                end
            end
        end else if (accept) begin
            for (int y = 0; y < 3; y++) begin
                win[y][0] <= win[y][1];
                win[y][1] <= win[y][2];
            end
            win[0][2] <= lb2_out;
            win[1][2] <= lb1_out;
            win[2][2] <= stream.gray_color;
        end
    end

    // Stage-1 valid: the window just loaded is a full interior window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
            s1_last  <= accept && last_pix;
        end
    end

    // Gradients, magnitude and output shaping from the current window.
    always_comb begin
        // NOTE: every variable gets a value on every path, so no latch is inferred.
        gx = GRAD_W'(win[0][2]) + (GRAD_W'(win[1][2]) << 1) + GRAD_W'(win[2][2])
           - GRAD_W'(win[0][0]) - (GRAD_W'(win[1][0]) << 1) - GRAD_W'(win[2][0]);
        gy = GRAD_W'(win[2][0]) + (GRAD_W'(win[2][1]) << 1) + GRAD_W'(win[2][2])
           - GRAD_W'(win[0][0]) - (GRAD_W'(win[0][1]) << 1) - GRAD_W'(win[0][2]);
        abs_gx = gx[GRAD_W-1] ? MAG_W'(-gx) : MAG_W'(gx);
        abs_gy = gy[GRAD_W-1] ? MAG_W'(-gy) : MAG_W'(gy);
        mag    = abs_gx + abs_gy;
        if (THRESHOLD == 0) begin
            shaped = (mag > MAG_W'(255)) ? 8'hFF : mag[PIX_W-1:0];
        end else begin
            shaped = (int'(mag) >= THRESHOLD) ? 8'hFF : 8'h00;
        end
    end

    // Output registers; the pixel holds between strobes, a restart drops the in-flight one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_valid <= 1'b0;
            edge_pixel <= '0;
            done       <= 1'b0;
        end else begin
            edge_valid <= s1_valid && !restart;
            done       <= s1_valid && s1_last && !restart;
            if (s1_valid && !restart) begin
                edge_pixel <= shaped;
            end
        end
    end

    assign stream.busy       = (state == RUN);
    assign stream.edge_valid = edge_valid;
    assign stream.edge_pixel = edge_pixel;
    assign stream.done       = done;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream: 8x4 frames at THRESHOLD 0/200/300
// sharing one stimulus, plus a 3x3 minimum-size instance.
module tb_sobel_edge_stream;

    typedef int row_t [6];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    sobel_edge_stream_if if_a ();
    sobel_edge_stream_if if_t200 ();
    sobel_edge_stream_if if_t300 ();
    sobel_edge_stream_if if_m ();

    assign if_t200.start      = if_a.start;
    assign if_t200.gray_valid = if_a.gray_valid;
    assign if_t200.gray_color = if_a.gray_color;
    assign if_t300.start      = if_a.start;
    assign if_t300.gray_valid = if_a.gray_valid;
    assign if_t300.gray_color = if_a.gray_color;

    sobel_edge_stream #(.IMG_W(8), .IMG_H(4), .THRESHOLD(0))   dut_a    (.clk_i(clk), .rst_i(rst), .stream(if_a));
    sobel_edge_stream #(.IMG_W(8), .IMG_H(4), .THRESHOLD(200)) dut_t200 (.clk_i(clk), .rst_i(rst), .stream(if_t200));
    sobel_edge_stream #(.IMG_W(8), .IMG_H(4), .THRESHOLD(300)) dut_t300 (.clk_i(clk), .rst_i(rst), .stream(if_t300));
    sobel_edge_stream #(.IMG_W(3), .IMG_H(3), .THRESHOLD(0))   dut_m    (.clk_i(clk), .rst_i(rst), .stream(if_m));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Captured output traffic per instance.
    logic [7:0] out_a[$];
    int         ocyc_a[$];
    int         exp_cyc_a[$];
    int         done_cnt_a, done_idx_a, done_bad_a;
    logic [7:0] last_a = 8'd0;
    int         hold_bad = 0;
    logic [7:0] out_t200[$];
    logic [7:0] out_t300[$];
    int         done_cnt_t200, done_cnt_t300;
    logic [7:0] out_m[$];
    int         ocyc_m[$];
    int         done_cnt_m, done_idx_m;

    always @(negedge clk) begin
        if (if_a.edge_valid === 1'b1) begin
            out_a.push_back(if_a.edge_pixel);
            ocyc_a.push_back(cyc);
        end
        if (if_a.done === 1'b1) begin
            done_cnt_a++;
            done_idx_a = out_a.size();
            if (if_a.edge_valid !== 1'b1) done_bad_a++;
        end
        if (rst) last_a = 8'd0;
        else if (if_a.edge_valid === 1'b1) last_a = if_a.edge_pixel;
        else if (if_a.edge_pixel !== last_a) hold_bad++;
    end

    always @(negedge clk) begin
        if (if_t200.edge_valid === 1'b1) out_t200.push_back(if_t200.edge_pixel);
        if (if_t300.edge_valid === 1'b1) out_t300.push_back(if_t300.edge_pixel);
        if (if_t200.done === 1'b1) done_cnt_t200++;
        if (if_t300.done === 1'b1) done_cnt_t300++;
        if (if_m.edge_valid === 1'b1) begin
            out_m.push_back(if_m.edge_pixel);
            ocyc_m.push_back(cyc);
        end
        if (if_m.done === 1'b1) begin
            done_cnt_m++;
            done_idx_m = out_m.size();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        out_a.delete();
        ocyc_a.delete();
        exp_cyc_a.delete();
        out_t200.delete();
        out_t300.delete();
        done_cnt_a = 0; done_idx_a = 0; done_bad_a = 0;
        done_cnt_t200 = 0; done_cnt_t300 = 0;
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd100;
            1:       return (c >= 4) ? 8'd255 : 8'd0;
            2:       return (c == 4) ? 8'd60 : 8'd0;
            default: return 8'd50;
        endcase
    endfunction

    task automatic pulse_start();
        if_a.start = 1'b1;
        tick();
        if_a.start = 1'b0;
    endtask

    // gap_mode: 0 continuous, 1 one idle cycle before each pixel, 2 random 0..3 idles.
    task automatic run_frame(input int mode, input int gap_mode, input int npix);
        for (int i = 0; i < npix; i++) begin
            int r = i / 8;
            int c = i % 8;
            int g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (g) tick();
            if (i == 31) check("busy_before_last", 32'(if_a.busy), 1);
            if_a.gray_valid = 1'b1;
            if_a.gray_color = pix_val(mode, r, c);
            if (r >= 2 && c >= 2) exp_cyc_a.push_back(cyc);
            tick();
            if_a.gray_valid = 1'b0;
            if (i == 31) check("busy_after_last", 32'(if_a.busy), 0);
        end
    endtask

    task automatic verify_a(input string tag, input row_t exp_row);
        check({tag, "_count"}, out_a.size(), 12);
        for (int i = 0; i < out_a.size() && i < 12; i++) begin
            check($sformatf("%s_pix%0d", tag, i), 32'(out_a[i]), exp_row[i % 6]);
            if (i < exp_cyc_a.size())
                check($sformatf("%s_lat%0d", tag, i), ocyc_a[i], exp_cyc_a[i] + 2);
        end
        check({tag, "_done_cnt"}, done_cnt_a, 1);
        check({tag, "_done_idx"}, done_idx_a, 12);
        check({tag, "_done_alone"}, done_bad_a, 0);
    endtask

    initial begin
        row_t zeros    = '{0, 0, 0, 0, 0, 0};
        row_t step_row = '{0, 0, 255, 255, 0, 0};
        row_t line_sat = '{0, 0, 240, 0, 240, 0};
        row_t line_thr = '{0, 0, 255, 0, 255, 0};
        logic [7:0] min_img [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        int last_cyc;

        if_a.start = 1'b0; if_a.gray_valid = 1'b0; if_a.gray_color = 8'd0;
        if_m.start = 1'b0; if_m.gray_valid = 1'b0; if_m.gray_color = 8'd0;
        clear_mon();
        done_cnt_m = 0; done_idx_m = 0;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(if_a.busy), 0);
        check("rst_edge_valid", 32'(if_a.edge_valid), 0);
        check("rst_edge_pixel", 32'(if_a.edge_pixel), 0);
        check("rst_done", 32'(if_a.done), 0);
        rst = 1'b0;
        tick();

        // Flat image
        clear_mon();
        pulse_start();
        check("busy_after_start", 32'(if_a.busy), 1);
        run_frame(0, 0, 32);
        repeat (5) tick();
        verify_a("flat", zeros);

        // Vertical step, saturating
        clear_mon();
        pulse_start();
        run_frame(1, 0, 32);
        repeat (5) tick();
        verify_a("step", step_row);

        // Single bright column: saturate / threshold 200 / threshold 300
        clear_mon();
        pulse_start();
        run_frame(2, 0, 32);
        repeat (5) tick();
        verify_a("line", line_sat);
        check("t200_count", out_t200.size(), 12);
        check("t300_count", out_t300.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < out_t200.size()) check($sformatf("t200_pix%0d", i), 32'(out_t200[i]), line_thr[i % 6]);
            if (i < out_t300.size()) check($sformatf("t300_pix%0d", i), 32'(out_t300[i]), 0);
        end
        check("t200_done", done_cnt_t200, 1);
        check("t300_done", done_cnt_t300, 1);

        // Step image with stalls
        clear_mon();
        pulse_start();
        run_frame(1, 1, 32);
        repeat (5) tick();
        verify_a("step_toggle", step_row);

        clear_mon();
        pulse_start();
        run_frame(1, 2, 32);
        repeat (5) tick();
        verify_a("step_gaps", step_row);

        // Restart mid-frame, then a complete flat-50 frame
        clear_mon();
        pulse_start();
        run_frame(1, 0, 20);
        pulse_start();
        clear_mon();
        run_frame(3, 0, 32);
        repeat (5) tick();
        verify_a("abort", zeros);

        // Reset mid-frame
        clear_mon();
        pulse_start();
        run_frame(1, 0, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_edge_valid", 32'(if_a.edge_valid), 0);
        check("midrst_edge_pixel", 32'(if_a.edge_pixel), 0);
        check("midrst_busy", 32'(if_a.busy), 0);
        check("midrst_done", 32'(if_a.done), 0);
        clear_mon();

        // Pixels while idle are ignored
        for (int i = 0; i < 10; i++) begin
            if_a.gray_valid = 1'b1;
            if_a.gray_color = 8'd255;
            tick();
        end
        if_a.gray_valid = 1'b0;
        repeat (4) tick();
        check("idle_outputs", out_a.size(), 0);
        check("idle_busy", 32'(if_a.busy), 0);
        clear_mon();
        pulse_start();
        run_frame(0, 0, 32);
        repeat (5) tick();
        verify_a("after_idle", zeros);

        // Minimum 3x3 frame: single window, Gx=8, Gy=24 -> 32
        if_m.start = 1'b1;
        tick();
        if_m.start = 1'b0;
        last_cyc = 0;
        for (int i = 0; i < 9; i++) begin
            if_m.gray_valid = 1'b1;
            if_m.gray_color = min_img[i];
            last_cyc = cyc;
            tick();
        end
        if_m.gray_valid = 1'b0;
        check("min_busy_after_last", 32'(if_m.busy), 0);
        repeat (5) tick();
        check("min_count", out_m.size(), 1);
        if (out_m.size() > 0) begin
            check("min_pix", 32'(out_m[0]), 32);
            check("min_lat", ocyc_m[0], last_cyc + 2);
        end
        check("min_done_cnt", done_cnt_m, 1);
        check("min_done_idx", done_idx_m, 1);

        check("pixel_hold", hold_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
